// File: rtl/row_cache_assoc_pkg.sv
// row_cache_assoc_pkg: shared state type, memory op codes and width helpers for the row cache
package row_cache_assoc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE, S_FLUSH} state_e;
  localparam logic MEM_FILL = 1'b0;
  localparam logic MEM_WB = 1'b1;
  function automatic int set_bits(input int chwidth, input int wayswidth);
    return chwidth - wayswidth;
  endfunction
  function automatic int tag_bits(input int addrwidth, input int chwidth, input int wayswidth);
    return addrwidth - set_bits(chwidth, wayswidth);
  endfunction
endpackage

// File: rtl/row_cache_assoc_if.sv
// row_cache_assoc_if: requester and backing-store signals of the row cache
interface row_cache_assoc_if #(parameter int CHWIDTH = 5, parameter int ADDRWIDTH = 17);
  logic rd, wr, sync, hold, ready, hit, mem_req, mem_we, mem_ack;
  logic [ADDRWIDTH-1:0] row_id, mem_row;
  logic [CHWIDTH-1:0] c_row_id, mem_crow;
  modport master (output rd, wr, row_id, sync, mem_ack,
                  input hold, ready, hit, c_row_id, mem_req, mem_we, mem_row, mem_crow);
  modport slave (input rd, wr, row_id, sync, mem_ack,
                 output hold, ready, hit, c_row_id, mem_req, mem_we, mem_row, mem_crow);
endinterface

// File: rtl/row_cache_assoc_lru.sv
// row_cache_assoc_lru: true-LRU age update and LRU way pick for one set
module row_cache_assoc_lru #(parameter int WAYSWIDTH = 1) (
  input  logic [(1<<WAYSWIDTH)-1:0][WAYSWIDTH-1:0] age_i,
  input  logic [WAYSWIDTH-1:0]                     used_i,
  input  logic                                     upd_i,
  output logic [(1<<WAYSWIDTH)-1:0][WAYSWIDTH-1:0] age_o,
  output logic [WAYSWIDTH-1:0]                     lru_o
);
  // the all-ones age is the LRU way; a use zeroes its age and ages every younger way by one
  always_comb begin
    lru_o = '0;
    for (int w = 0; w < (1 << WAYSWIDTH); w++) begin
      age_o[w] = !upd_i ? age_i[w] : WAYSWIDTH'(w) == used_i ? '0 :
                 age_i[w] < age_i[used_i] ? age_i[w] + 1'b1 : age_i[w];
      lru_o = &age_i[w] ? WAYSWIDTH'(w) : lru_o;
    end
  end
endmodule

// File: rtl/row_cache_assoc.sv
// row_cache_assoc: N-way set-associative DRAM row cache with writeback and flush
module row_cache_assoc
  import row_cache_assoc_pkg::*;
#(
  parameter int CHWIDTH = 5,
  parameter int WAYSWIDTH = 1,
  parameter int ADDRWIDTH = 17
) (
  input logic clk,
  input logic rst_n,
  row_cache_assoc_if.slave bus
);
  localparam int SB = set_bits(CHWIDTH, WAYSWIDTH);
  localparam int TB = tag_bits(ADDRWIDTH, CHWIDTH, WAYSWIDTH);
  localparam int WAYS = 1 << WAYSWIDTH;
  localparam int SETS = 1 << SB;
  localparam int ROWS = 1 << CHWIDTH;
  state_e state_q, state_d;
  logic [ADDRWIDTH-1:0] row_q, row_d;
  logic [CHWIDTH-1:0] line_q, line_d;
  logic wr_q, wr_d, hit_q, hit_d, pend_q, pend_d, fl_q, fl_d;
  logic [ROWS-1:0][TB-1:0] tag_q;
  logic [ROWS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][WAYSWIDTH-1:0] age_q;
  logic [WAYS-1:0][WAYSWIDTH-1:0] age_n;
  logic [SB-1:0] set;
  logic [TB-1:0] tag;
  logic hit_any, inv_any, tag_we;
  logic [WAYSWIDTH-1:0] hit_way, inv_way, lru_way;
  logic [CHWIDTH-1:0] victim;
  assign set = row_q[SB-1:0];
  assign tag = row_q[ADDRWIDTH-1:SB];
  assign victim = {set, inv_any ? inv_way : lru_way};
  row_cache_assoc_lru #(.WAYSWIDTH(WAYSWIDTH)) u_lru (
    .age_i(age_q[set]),
    .used_i(line_q[WAYSWIDTH-1:0]),
    .upd_i(state_q == S_DONE),
    .age_o(age_n),
    .lru_o(lru_way)
  );
  // tag compare across the set; descending scan so the lowest matching/invalid way wins
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[{set, WAYSWIDTH'(w)}] && tag_q[{set, WAYSWIDTH'(w)}] == tag) begin
        hit_any = 1'b1;
        hit_way = WAYSWIDTH'(w);
      end
      if (!valid_q[{set, WAYSWIDTH'(w)}]) begin
        inv_any = 1'b1;
        inv_way = WAYSWIDTH'(w);
      end
    end
  end
  // next state: access path IDLE-LOOKUP-(WB)-(FILL)-DONE, flush path FLUSH-(WB)-FLUSH
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    line_d = line_q;
    wr_d = wr_q;
    hit_d = hit_q;
    fl_d = fl_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_we = 1'b0;
    pend_d = pend_q | (bus.sync & (state_q != S_IDLE | bus.rd | bus.wr));
    case (state_q)
      S_IDLE:
        if (bus.rd | bus.wr) begin
          row_d = bus.row_id;
          wr_d = bus.wr;
          state_d = S_LOOKUP;
        end else if (bus.sync | pend_q) begin
          line_d = '0;
          fl_d = 1'b1;
          pend_d = 1'b0;
          state_d = S_FLUSH;
        end
      S_LOOKUP: begin
        hit_d = hit_any;
        line_d = hit_any ? {set, hit_way} : victim;
        state_d = hit_any ? S_DONE : (valid_q[victim] & dirty_q[victim]) ? S_WB : S_FILL;
      end
      S_WB:
        if (bus.mem_ack) begin
          dirty_d[line_q] = 1'b0;
          line_d = fl_q && !(&line_q) ? line_q + 1'b1 : line_q;
          fl_d = fl_q && !(&line_q);
          state_d = !fl_q ? S_FILL : &line_q ? S_IDLE : S_FLUSH;
        end
      S_FILL:
        if (bus.mem_ack) begin
          tag_we = 1'b1;
          valid_d[line_q] = 1'b1;
          state_d = S_DONE;
        end
      S_DONE: begin
        dirty_d[line_q] = dirty_q[line_q] | wr_q;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        line_d = !(valid_q[line_q] & dirty_q[line_q]) && !(&line_q) ? line_q + 1'b1 : line_q;
        fl_d = (valid_q[line_q] & dirty_q[line_q]) || !(&line_q);
        state_d = (valid_q[line_q] & dirty_q[line_q]) ? S_WB : &line_q ? S_IDLE : S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and array registers; reset drops any transfer in flight and leaves ages = way index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q <= '0;
      line_q <= '0;
      wr_q <= 1'b0;
      hit_q <= 1'b0;
      pend_q <= 1'b0;
      fl_q <= 1'b0;
      tag_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAYSWIDTH'(w);
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      line_q <= line_d;
      wr_q <= wr_d;
      hit_q <= hit_d;
      pend_q <= pend_d;
      fl_q <= fl_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      if (tag_we) tag_q[line_q] <= tag;
      if (state_q == S_DONE) age_q[set] <= age_n;
    end
  assign bus.hold = state_q != S_IDLE;
  assign bus.ready = state_q == S_DONE;
  assign bus.hit = bus.ready & hit_q;
  assign bus.c_row_id = bus.ready ? line_q : '0;
  assign bus.mem_req = state_q == S_WB || state_q == S_FILL;
  assign bus.mem_we = state_q == S_WB ? MEM_WB : MEM_FILL;
  assign bus.mem_row = state_q == S_WB ? {tag_q[line_q], line_q[CHWIDTH-1:WAYSWIDTH]} :
                       state_q == S_FILL ? row_q : '0;
  assign bus.mem_crow = bus.mem_req ? line_q : '0;
endmodule

// File: tb/tb_row_cache_assoc.sv
// tb_row_cache_assoc: directed scoreboard bench for the 4-set x 2-way row cache
module tb_row_cache_assoc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0, mem_cnt = 0, rdy_cnt = 0, m0, r0, lat, n;
  logic [11:0] exp_mem[$];
  logic [3:0] exp_rsp[$];
  always #5 clk = ~clk;
  row_cache_assoc_if #(.CHWIDTH(3), .ADDRWIDTH(8)) bus ();
  row_cache_assoc #(.CHWIDTH(3), .WAYSWIDTH(1), .ADDRWIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_mem(input logic we, input logic [7:0] row, input logic [2:0] crow);
    exp_mem.push_back({we, row, crow});
  endtask
  task automatic push_rsp(input logic h, input logic [2:0] crow);
    exp_rsp.push_back({h, crow});
  endtask
  task automatic access(input logic w, input logic [7:0] row, input logic sy, output int l);
    bus.wr = w;
    bus.rd = !w;
    bus.row_id = row;
    bus.sync = sy;
    @(negedge clk);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.sync = 1'b0;
    chk("hold_busy", bus.hold, 1);
    l = 1;
    while (!bus.ready && l < 200) begin
      @(negedge clk);
      l++;
    end
    chk("ready_seen", bus.ready, 1);
    @(negedge clk);
  endtask
  task automatic do_sync(input string tag);
    int k;
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    chk({tag, "_hold"}, bus.hold, 1);
    k = 0;
    while (bus.hold && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, bus.hold, 0);
  endtask
  // response and memory side: pops expectations as the DUT produces them; acks 3 cycles late
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready) begin
        rdy_cnt++;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(exp_rsp.size()), 1);
        else chk("rsp", {bus.hit, bus.c_row_id}, exp_rsp.pop_front());
      end
      if (!rst_n) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_req) begin
        if (cnt == 0) begin
          mem_cnt++;
          if (exp_mem.size() == 0) chk("mem_unexpected", 32'(exp_mem.size()), 1);
          else chk("mem", {bus.mem_we, bus.mem_row, bus.mem_crow}, exp_mem.pop_front());
        end
        cnt++;
        if (cnt == 3) bus.mem_ack = 1'b1;
      end
    end
  end
  initial begin
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.sync = 1'b0;
    bus.row_id = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.hold, bus.ready, bus.hit, bus.c_row_id, bus.mem_req, bus.mem_we,
                        bus.mem_row, bus.mem_crow}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_mem(0, 8'h05, 2); push_rsp(0, 2); m0 = mem_cnt;
    access(0, 8'h05, 0, lat);
    chk("t1_memreqs", mem_cnt - m0, 1);
    push_rsp(1, 2); m0 = mem_cnt;
    access(0, 8'h05, 0, lat);
    chk("t2_hit_latency", lat, 2);
    chk("t2_no_mem", mem_cnt - m0, 0);
    push_mem(0, 8'h09, 3); push_rsp(0, 3);
    access(1, 8'h09, 0, lat);
    push_mem(0, 8'h0D, 2); push_rsp(0, 2); m0 = mem_cnt;
    access(0, 8'h0D, 0, lat);
    chk("t3_clean_evict", mem_cnt - m0, 1);
    push_mem(1, 8'h09, 3); push_mem(0, 8'h11, 3); push_rsp(0, 3); m0 = mem_cnt;
    access(0, 8'h11, 0, lat);
    chk("t4_wb_fill", mem_cnt - m0, 2);
    push_mem(0, 8'h00, 0); push_rsp(0, 0);
    access(0, 8'h00, 0, lat);
    push_mem(0, 8'h04, 1); push_rsp(0, 1);
    access(1, 8'h04, 0, lat);
    push_mem(0, 8'h03, 6); push_rsp(0, 6);
    access(1, 8'h03, 0, lat);
    push_mem(1, 8'h04, 1); push_mem(1, 8'h03, 6); m0 = mem_cnt; r0 = rdy_cnt;
    do_sync("t5_flush");
    chk("t5_wbs", mem_cnt - m0, 2);
    chk("t5_no_ready", rdy_cnt - r0, 0);
    m0 = mem_cnt;
    do_sync("t5_reflush");
    chk("t5_clean", mem_cnt - m0, 0);
    push_mem(0, 8'h15, 2);
    bus.rd = 1'b1;
    bus.row_id = 8'h15;
    @(negedge clk);
    bus.rd = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_fill", {bus.mem_req, bus.mem_we}, 2'b10);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_outputs", {bus.mem_req, bus.hold, bus.ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_mem(0, 8'h15, 2); push_rsp(0, 2);
    access(0, 8'h15, 0, lat);
    push_mem(0, 8'h07, 6); push_rsp(0, 6); push_mem(1, 8'h07, 6); m0 = mem_cnt;
    access(1, 8'h07, 1, lat);
    @(negedge clk);
    chk("t7_flush_started", bus.hold, 1);
    n = 0;
    while (bus.hold && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t7_flush_done", bus.hold, 0);
    chk("t7_mem", mem_cnt - m0, 2);
    chk("mem_queue_empty", 32'(exp_mem.size()), 0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
